// File: rtl/nios_system_pio_gen_if.sv
// nios_system_pio_gen_if
// Avalon-MM s1 slave bus for the general-purpose I/O block.
//   address    : word address (register select)
//   chipselect : slave select
//   read_n     : active-low read strobe
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
interface nios_system_pio_gen_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output read_n,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read_n,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_pio_gen.sv
// nios_system_pio_gen
// Parametrised Avalon-MM GPIO slave: output data register with per-bit
// direction, atomic set/clear, two-flop input synchronizer and optional
// edge capture with a maskable level interrupt.
//
// Optional feature macro: PIO_EDGE_IRQ_EN (edge capture, IRQMASK, EDGE, irq).
//
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   s1       : Avalon-MM slave bus (see nios_system_pio_gen_if)
//   in_port  : external pin inputs (asynchronous)
//   out_port : output data register
//   oe_port  : per-bit output enable (1 = output)
//   irq      : level interrupt
//
// Register map: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGE (W1C), 4 OUTSET, 5 OUTCLR.
module nios_system_pio_gen #(
  parameter int               WIDTH       = 32'sd8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               EDGE_TYPE   = 32'sd0
) (
  input  logic                 clk,
  input  logic                 reset,
  nios_system_pio_gen_if.slave s1,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     oe_port,
  output logic                 irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic             wr_s;
  logic             rd_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] pin_view_s;
  logic [31:0]      rdata_s;

  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] in_sync_r;
  logic [31:0]      readdata_r;

  assign wr_s    = s1.chipselect & ~s1.write_n;
  assign rd_s    = s1.chipselect & ~s1.read_n;
  assign wdata_s = s1.writedata[WIDTH-1:0];

  // Output bits show the driven value, input bits show the synchronized pin.
  assign pin_view_s = (data_out_r & dir_r) | (in_sync_r & ~dir_r);

  // Output data and direction registers, including atomic set/clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_r <= RESET_VALUE;
      dir_r      <= {WIDTH{1'b0}};
    end else if (wr_s) begin
      case (s1.address)
        ADDR_DATA:   data_out_r <= wdata_s;
        ADDR_DIR:    dir_r      <= wdata_s;
        ADDR_OUTSET: data_out_r <= data_out_r | wdata_s;
        ADDR_OUTCLR: data_out_r <= data_out_r & ~wdata_s;
        default: begin
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r   <= {WIDTH{1'b0}};
      in_sync_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r   <= in_port;
      in_sync_r <= sync1_r;
    end
  end

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edge_cap_r;
  logic [1:0]       warm_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic             armed_s;

  assign rise_s = in_sync_r & ~prev_r;
  assign fall_s = ~in_sync_r & prev_r;
  assign clr_s  = (wr_s && (s1.address == ADDR_EDGE)) ? wdata_s : {WIDTH{1'b0}};
  // Capture stays disarmed until prev holds a real pin sample after reset,
  // so pins held high through reset release do not look like rising edges.
  assign armed_s = (warm_r == 2'd3);

  // Select which transitions count as an edge.
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      32'sd1:  edge_s = fall_s;
      32'sd2:  edge_s = rise_s | fall_s;
      default: edge_s = rise_s;
    endcase
  end

  // Previous-sample register, warm-up counter, IRQ mask and edge capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r     <= {WIDTH{1'b0}};
      mask_r     <= {WIDTH{1'b0}};
      edge_cap_r <= {WIDTH{1'b0}};
      warm_r     <= 2'd0;
    end else begin
      prev_r <= in_sync_r;
      if (!armed_s) begin
        warm_r <= warm_r + 2'd1;
      end
      if (wr_s && (s1.address == ADDR_MASK)) begin
        mask_r <= wdata_s;
      end
      // A new edge wins over a simultaneous clear of the same bit.
      if (armed_s) begin
        edge_cap_r <= (edge_cap_r & ~clr_s) | edge_s;
      end else begin
        edge_cap_r <= edge_cap_r & ~clr_s;
      end
    end
  end

  assign irq = |(edge_cap_r & mask_r);
`else
  logic unused_s;
  // Edge type only matters when capture is built in.
  assign unused_s = (EDGE_TYPE > 32'sd0);
  assign irq      = 1'b0;
`endif

  // Read data multiplexer; unused upper bits and unmapped addresses read 0.
  always_comb begin
    rdata_s = 32'h0;
    case (s1.address)
      ADDR_DATA: rdata_s[WIDTH-1:0] = pin_view_s;
      ADDR_DIR:  rdata_s[WIDTH-1:0] = dir_r;
`ifdef PIO_EDGE_IRQ_EN
      ADDR_MASK: rdata_s[WIDTH-1:0] = mask_r;
      ADDR_EDGE: rdata_s[WIDTH-1:0] = edge_cap_r;
`endif
      default:   rdata_s = 32'h0;
    endcase
  end

  // Registered read data, held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= 32'h0;
    end else if (rd_s) begin
      readdata_r <= rdata_s;
    end
  end

  // Write data bits above WIDTH are intentionally dropped.
  logic unused_wdata_s;
  assign unused_wdata_s = ^s1.writedata;

  assign s1.readdata = readdata_r;
  assign out_port    = data_out_r;
  assign oe_port     = dir_r;

endmodule

// File: doc/nios_system_pio_gen.md
# nios_system_pio_gen

Parametrised Avalon-MM general-purpose I/O slave for the Nios II system, replacing the fixed-width output-only PIO registers (e.g. HPI address/data/control ports). It provides a configurable-width output register with per-bit direction, atomic bit set/clear, a two-flop input synchronizer, and edge capture with a maskable level interrupt. It sits on the system interconnect as one s1 slave per peripheral pin group.

## Interface

Parameters:
- WIDTH, 8, number of I/O bits (1..32).
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits).
- EDGE_TYPE, 0, edge detected for capture: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register select (word address).
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- in_port  in  WIDTH  external pin inputs (asynchronous).
- out_port  out  WIDTH  output data register.
- oe_port  out  WIDTH  per-bit output enable (direction register).
- irq  out  1  level interrupt.

## Operation

- Register map (wr = chipselect & ~write_n, rd = chipselect & ~read_n):
  - 0 DATA: write loads data_out; read returns (data_out & dir) | (in_sync & ~dir).
  - 1 DIR: read/write; 1 = output.
  - 2 IRQMASK: read/write.
  - 3 EDGE: read capture bits; write-1-to-clear.
  - 4 OUTSET: write sets data_out bits where writedata=1; reads 0.
  - 5 OUTCLR: write clears data_out bits where writedata=1; reads 0.
  - 6, 7: writes ignored, reads 0.
- Input path: in_port → sync1 → in_sync (two flops); prev holds in_sync delayed one cycle.
- Edge detect: rise = in_sync & ~prev; fall = ~in_sync & prev; edge selected by EDGE_TYPE.
- Capture: edge_cap <= (edge_cap & ~clr) | edge, where clr = writedata bits on wr to address 3. A new edge in the same cycle as a clear of that bit leaves the bit set (edge wins).
- irq = |(edge_cap & irq_mask), combinational from registers.
- Edge detection runs on all bits regardless of DIR.
- Reset values: data_out = RESET_VALUE, dir = 0, irq_mask = 0, edge_cap = 0, sync1/in_sync/prev = 0, readdata = 0, irq = 0.
- Writes of any width land immediately; no read side effects.

## Timing

- Write: register updates at the clk edge on which wr is sampled; out_port/oe_port change the same edge.
- Read latency 1: readdata valid the cycle after rd is sampled; it holds its value until the next read.
- Pin to in_sync: 2 cycles; pin edge to edge_cap set: 3 cycles; to irq: 3 cycles (if masked in).
- Reset asserted mid-operation: all state clears asynchronously; capture restarts cleanly, so no spurious edge is captured for pins held high through reset release.

## Configuration

- PIO_EDGE_IRQ_EN defined: edge capture, IRQMASK, EDGE registers and irq are present as above.
- Undefined: no prev, edge_cap or irq_mask flops; addresses 2 and 3 read 0 and ignore writes; irq tied 0. The DATA/DIR/OUTSET/OUTCLR behaviour is unchanged.

## Test plan

- Reset with RESET_VALUE=8'hA5 → out_port=8'hA5, oe_port=0, irq=0, and a read of address 0 with in_port=8'h3C returns 8'h3C.
- Write DIR=8'hF0, DATA=8'h12, in_port=8'h0F → read address 0 returns 8'h1F one cycle after rd.
- DATA=8'h0F; OUTSET 8'h80 → 8'h8F; then OUTCLR 8'h01 → 8'h8E; reads of 4/5 return 0.
- EDGE_TYPE=0, IRQMASK=8'h04: bit2 pin 0→1 → EDGE reads 8'h04 and irq=1 three cycles later; write 8'h04 to EDGE → irq=0 next cycle.
- Second rising edge on bit2 timed to reach edge_cap in the same cycle as the EDGE clear write → bit stays 1 and irq stays 1.
- Assert reset while edge_cap=8'hFF and irq=1 → all registers clear immediately; with PIO_EDGE_IRQ_EN undefined, reads of 2 and 3 return 0 and irq is constant 0.
